// File: rtl/cla_multiword_seq.sv
// Multi-cycle wide adder: one N_BIT slice per cycle through a shared carry-lookahead slice adder.
// Optional macro CLA_SEQ_SUB_EN adds a 'sub' port for x-y (two's complement) operation.

module cla_adder_8bits #(
  parameter int N_BIT = 8
) (
  input  logic [N_BIT-1:0] a,
  input  logic [N_BIT-1:0] b,
  input  logic             cin,
  output logic [N_BIT-1:0] sum,
  output logic             cout
);

  logic [N_BIT-1:0] gen;
  logic [N_BIT-1:0] prop;
  logic [N_BIT:0]   carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Each carry is a flat sum of products of generate/propagate terms, not a ripple chain
  always_comb begin
    logic acc;
    logic prod;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < N_BIT; i++) begin
      acc  = gen[i];
      prod = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prod & gen[j]);
        prod = prod & prop[j];
      end
      carry[i+1] = acc | (prod & cin);
    end
  end

  assign sum  = prop ^ carry[N_BIT-1:0];
  assign cout = carry[N_BIT];

endmodule

module cla_multiword_seq #(
  parameter int N_BIT = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WORDS*N_BIT-1:0] x,
  input  logic [WORDS*N_BIT-1:0] y,
  input  logic                   cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [WORDS*N_BIT-1:0] sum,
  output logic                   cout
);

  localparam int W     = WORDS * N_BIT;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             carry_reg;
  logic [W-1:0]     x_reg;
  logic [W-1:0]     y_reg;
  logic [W-1:0]     sum_reg;
  logic [N_BIT-1:0] a_slice;
  logic [N_BIT-1:0] b_slice;
  logic [N_BIT-1:0] slice_sum;
  logic             slice_cout;
  logic             accept;
  logic             last;
`ifdef CLA_SEQ_SUB_EN
  logic             sub_reg;
`endif

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (idx == IDX_W'(WORDS - 1));

  always_comb begin
    a_slice = x_reg[idx*N_BIT +: N_BIT];
`ifdef CLA_SEQ_SUB_EN
    b_slice = sub_reg ? ~y_reg[idx*N_BIT +: N_BIT] : y_reg[idx*N_BIT +: N_BIT];
`else
    b_slice = y_reg[idx*N_BIT +: N_BIT];
`endif
  end

  cla_adder_8bits #(.N_BIT(N_BIT)) u_adder (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Start is only honoured in IDLE/DONE; in RUN the operands and partial result are untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      sum_reg   <= '0;
`ifdef CLA_SEQ_SUB_EN
      sub_reg   <= 1'b0;
`endif
    end else if (accept) begin
      state   <= RUN;
      idx     <= '0;
      x_reg   <= x;
      y_reg   <= y;
      sum_reg <= '0;
`ifdef CLA_SEQ_SUB_EN
      sub_reg   <= sub;
      carry_reg <= sub ? 1'b1 : cin;
`else
      carry_reg <= cin;
`endif
    end else begin
      case (state)
        RUN: begin
          sum_reg[idx*N_BIT +: N_BIT] <= slice_sum;
          carry_reg                   <= slice_cout;
          if (last) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The final slice carry stays in carry_reg, so it doubles as the held cout
  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sum_reg;
  assign cout = carry_reg;

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Randomised scoreboard bench for cla_multiword_seq (N_BIT=8, WORDS=4); covers sub mode when CLA_SEQ_SUB_EN is defined.

module tb_cla_multiword_seq;

  localparam int N_BIT = 8;
  localparam int WORDS = 4;
  localparam int W     = WORDS * N_BIT;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  cla_multiword_seq #(.N_BIT(N_BIT), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .cin   (cin),
`ifdef CLA_SEQ_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           acc;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] held_sum = '0;
  bit           held_valid = 1'b0;

  task automatic checkOutput(input string name, input logic [W:0] act, input logic [W:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference: wide integer arithmetic; subtraction reports "no borrow" as x>=y
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s, input int acc);
    exp_t        e;
    logic [W:0]  r;
    if (s) begin
      r      = {1'b0, a} - {1'b0, b};
      e.sum  = r[W-1:0];
      e.cout = (a >= b);
    end else begin
      r      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      e.sum  = r[W-1:0];
      e.cout = r[W];
    end
    e.acc = acc;
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse and checks hold behaviour between operations
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL spurious_done: got done=1 want no pending result");
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("sum", {1'b0, sum}, {1'b0, mon_e.sum});
          checkOutput("cout", {{W{1'b0}}, cout}, {{W{1'b0}}, mon_e.cout});
          checkOutput("latency", (W+1)'(cyc - mon_e.acc), (W+1)'(WORDS));
          checkOutput("busy_in_done", {{W{1'b0}}, busy}, '0);
          held_sum   = sum;
          held_valid = 1'b1;
        end
      end else if (!busy && held_valid) begin
        checkOutput("hold_sum", {1'b0, sum}, {1'b0, held_sum});
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c, input logic s);
    x     = a;
    y     = b;
    cin   = c;
`ifdef CLA_SEQ_SUB_EN
    sub   = s;
`else
    sub   = 1'b0;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(model(a, b, c, sub, cyc));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitReady();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("[TB] FAIL ready_timeout: got busy=1 want busy=0 within 100 cycles");
    end
  endtask

  task automatic waitDone();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: got done=0 want done=1 within 100 cycles");
    end
  endtask

  task automatic waitQueueEmpty();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL result_timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, {{W{1'b0}}, busy}, '0);
    checkOutput({tag, "_done"}, {{W{1'b0}}, done}, '0);
    checkOutput({tag, "_sum"},  {1'b0, sum}, '0);
    checkOutput({tag, "_cout"}, {{W{1'b0}}, cout}, '0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got simulation still running want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;

    // Power-on reset, two cycles low
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkIdleOutputs("reset");

    $display("[TB] carry ripple across a slice boundary");
    applyStimulus(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    waitQueueEmpty();

    $display("[TB] full carry chain followed by back-to-back start");
    waitReady();
    applyStimulus(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    waitDone();
    applyStimulus(32'h44444444, 32'h29292929, 1'b1, 1'b0);
    waitQueueEmpty();

    $display("[TB] start pulse during RUN is ignored");
    waitReady();
    applyStimulus(32'd1, 32'd1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    x     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    waitQueueEmpty();
    repeat (WORDS + 3) @(negedge clk);

    $display("[TB] reset mid-RUN abandons the operation");
    waitReady();
    applyStimulus(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    held_valid = 1'b0;
    #1;
    checkIdleOutputs("midrun_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < WORDS + 4; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checkOutput("no_done_after_reset", (W+1)'(seen), '0);

`ifdef CLA_SEQ_SUB_EN
    $display("[TB] subtract mode");
    waitReady();
    applyStimulus(32'd5, 32'd7, 1'b0, 1'b1);
    waitDone();
    applyStimulus(32'd7, 32'd5, 1'b0, 1'b1);
    waitQueueEmpty();
`endif

    $display("[TB] randomised operations");
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = '1;
        1: rb = ~ra;
        2: rb = ra;
        default: ;
      endcase
`ifdef CLA_SEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      if ($urandom_range(0, 1) == 1 && exp_q.size() != 0) waitDone();
      else waitReady();
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), rs);
    end
    waitQueueEmpty();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
